// File: rtl/dm_store_buffer.sv
// Store buffer and DM port arbiter: queues stores, drains one per cycle, gives loads the bus first.
// Optional macro DM_STORE_FWD_EN forwards buffered data to matching loads instead of stalling them.
module dm_store_buffer #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 32,
    parameter  int DW    = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_stall,
    output logic          ld_fwd,
    output logic          dm_wr,
    output logic          dm_rd,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    last_addr_q;
    logic [DW-1:0]    last_wdata_q;

    logic push;
    logic pop;
    logic hit;
    logic ld_bus;
`ifdef DM_STORE_FWD_EN
    logic [DW-1:0] hit_data;
`endif

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign st_ready = (count_q < CW'(DEPTH));
    assign push     = st_valid && st_ready;

    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        logic [PW-1:0] idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hit = 1'b0;
        idx = head_q;
`ifdef DM_STORE_FWD_EN
        hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (addr_mem[idx][AW-1:2] == ld_addr[AW-1:2])) begin
                hit = 1'b1;
`ifdef DM_STORE_FWD_EN
                hit_data = data_mem[idx];
`endif
            end
        end
    end

    // Only a load that actually needs DM takes the bus; a matched load lets the drain run.
    assign ld_bus   = ld_valid && !hit;
    assign pop      = !empty && !ld_bus;
    assign dm_wr    = pop;
    assign dm_rd    = ld_bus;
    assign dm_addr  = pop ? addr_mem[head_q] : (ld_bus ? ld_addr : last_addr_q);
    assign dm_wdata = pop ? data_mem[head_q] : last_wdata_q;

`ifdef DM_STORE_FWD_EN
    assign ld_stall = 1'b0;
    assign ld_fwd   = ld_valid && hit;
    assign ld_data  = ld_bus ? dm_rdata : (ld_fwd ? hit_data : '0);
`else
    assign ld_stall = ld_valid && hit;
    assign ld_fwd   = 1'b0;
    assign ld_data  = ld_bus ? dm_rdata : '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            if (push) begin
                tail_q          <= tail_q + PW'(1);
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q          <= head_q + PW'(1);
                valid_q[head_q] <= 1'b0;
            end
            count_q      <= count_q + CW'(push) - CW'(pop);
            last_addr_q  <= dm_addr;
            last_wdata_q <= dm_wdata;
        end
    end

    // NOTE: payload storage is deliberately not reset; valid_q alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= st_addr;
            data_mem[tail_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: directed scenarios plus random traffic against a queue-based model.
// Expectations follow DM_STORE_FWD_EN the same way the design does.
module tb_dm_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        ld_fwd;
    logic        dm_wr;
    logic        dm_rd;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        empty;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    dm_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_stall (ld_stall),
        .ld_fwd   (ld_fwd),
        .dm_wr    (dm_wr),
        .dm_rd    (dm_rd),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .empty    (empty),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'(12 - 4 * i);
    endfunction

    // Data memory attached to the DUT: writes land on the negedge, reads are combinational.
    logic [31:0] dm_mem [64];
    initial for (int i = 0; i < 64; i++) dm_mem[i] = init_word(i);
    always @(negedge clk) if (dm_wr) dm_mem[dm_addr[7:2]] <= dm_wdata;
    assign dm_rdata = dm_mem[dm_addr[7:2]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: FIFO of pending stores and the memory image they should produce.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] ref_mem [64];
    logic [31:0] last_addr  = '0;
    logic [31:0] last_wdata = '0;
    initial for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    always @(negedge clk) begin : compare
        int          n;
        int          mi;
        logic        hit;
        logic        bus;
        logic        drn;
        logic [31:0] ea;
        logic [31:0] ew;
        if (!reset) begin
            check("rst_count", count, 0);
            check("rst_empty", empty, 1);
            check("rst_st_ready", st_ready, 1);
            check("rst_dm_wr", dm_wr, 0);
            check("rst_dm_rd", dm_rd, 0);
            check("rst_ld_stall", ld_stall, 0);
            check("rst_ld_fwd", ld_fwd, 0);
            check("rst_dm_addr", dm_addr, 0);
            check("rst_dm_wdata", dm_wdata, 0);
            check("rst_ld_data", ld_data, 0);
            mq.delete();
            last_addr  = '0;
            last_wdata = '0;
        end else begin
            n  = mq.size();
            mi = -1;
            for (int i = 0; i < n; i++)
                if (mq[i].addr[31:2] == ld_addr[31:2]) mi = i;
            hit = ld_valid && (mi >= 0);
            bus = ld_valid && !hit;
            drn = (n > 0) && !bus;
            ea  = drn ? mq[0].addr : (bus ? ld_addr : last_addr);
            ew  = drn ? mq[0].data : last_wdata;

            check("count", count, n);
            check("empty", empty, n == 0);
            check("st_ready", st_ready, n < DEPTH);
            check("dm_wr", dm_wr, drn);
            check("dm_rd", dm_rd, bus);
            check("dm_addr", dm_addr, ea);
            check("dm_wdata", dm_wdata, ew);
`ifdef DM_STORE_FWD_EN
            check("ld_fwd", ld_fwd, hit);
            check("ld_stall", ld_stall, 0);
            if (hit) check("ld_data_fwd", ld_data, mq[mi].data);
`else
            check("ld_stall", ld_stall, hit);
            check("ld_fwd", ld_fwd, 0);
`endif
            if (bus) check("ld_data_dm", ld_data, ref_mem[ld_addr[7:2]]);
            if (!ld_valid) check("ld_data_idle", ld_data, 0);

            last_addr  = ea;
            last_wdata = ew;
            if (drn) begin
                ref_mem[mq[0].addr[7:2]] = mq[0].data;
                void'(mq.pop_front());
            end
            if (st_valid && n < DEPTH) mq.push_back('{addr: st_addr, data: st_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        int g;
        g        = 0;
        st_valid = 1'b0;
        ld_valid = 1'b0;
        mid();
        while (!empty && g < 20) begin
            tick();
            mid();
            g++;
        end
        check(name, empty, 1);
        tick();
    endtask

    task automatic load_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        ld_valid = 1'b1;
        ld_addr  = a;
        mid();
        check(name, ld_data, exp);
        tick();
        ld_valid = 1'b0;
    endtask

    initial begin : stimulus
        int accepted;
        int guard;
        logic ok;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        reset    = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            mid();
            check("idle_empty", empty, 1);
            check("idle_count", count, 0);
            check("idle_dm_wr", dm_wr, 0);
            check("idle_st_ready", st_ready, 1);
            tick();
        end

        // Single store reaches DM exactly one cycle after acceptance
        st_valid = 1'b1; st_addr = 32'h4; st_data = 32'hAA;
        mid();
        check("single_accept", st_ready, 1);
        tick();
        st_valid = 1'b0;
        mid();
        check("single_dm_wr", dm_wr, 1);
        check("single_dm_addr", dm_addr, 32'h4);
        check("single_dm_wdata", dm_wdata, 32'hAA);
        tick();
        mid();
        check("single_dm_wr_once", dm_wr, 0);
        tick();
        load_check("single_readback", 32'h4, 32'hAA);

        // Fill while a non-matching load blocks the drain, then release and wrap
        ld_valid = 1'b1; ld_addr = 32'h8;
        for (int j = 0; j < 4; j++) begin
            st_valid = 1'b1; st_addr = 32'h20 + 32'(4 * j); st_data = 32'h100 + 32'(j);
            mid();
            check("fill_ready", st_ready, 1);
            check("fill_ld_data", ld_data, 32'h4);
            tick();
        end
        st_addr = 32'h30; st_data = 32'h104;
        mid();
        check("fill_full_ready", st_ready, 0);
        check("fill_full_count", count, 4);
        check("fill_full_ld_data", ld_data, 32'h4);
        tick();
        ld_valid = 1'b0;
        accepted = 4;
        guard    = 0;
        while (accepted < 6 && guard < 40) begin
            st_valid = 1'b1; st_addr = 32'h20 + 32'(4 * accepted); st_data = 32'h100 + 32'(accepted);
            mid();
            ok = st_ready;
            tick();
            if (ok) accepted++;
            guard++;
        end
        check("fill_accept_all", accepted, 6);
        wait_empty("fill_drained");
        for (int j = 0; j < 6; j++)
            load_check("fill_readback", 32'h20 + 32'(4 * j), 32'h100 + 32'(j));

        // Load priority over buffered stores
        ld_valid = 1'b1; ld_addr = 32'h0;
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h210;
        tick();
        st_addr = 32'h14; st_data = 32'h214;
        tick();
        st_valid = 1'b0;
        mid();
        check("prio_dm_rd", dm_rd, 1);
        check("prio_dm_wr", dm_wr, 0);
        check("prio_ld_data", ld_data, 32'd12);
        check("prio_count", count, 2);
        tick();
        wait_empty("prio_drained");

`ifdef DM_STORE_FWD_EN
        // Forwarding from the youngest matching entry
        ld_valid = 1'b1; ld_addr = 32'h0;
        st_valid = 1'b1; st_addr = 32'h4; st_data = 32'h11;
        tick();
        st_data = 32'h22;
        tick();
        st_valid = 1'b0; ld_addr = 32'h4;
        mid();
        check("fwd_ld_fwd", ld_fwd, 1);
        check("fwd_ld_data", ld_data, 32'h22);
        check("fwd_ld_stall", ld_stall, 0);
        check("fwd_dm_wr", dm_wr, 1);
        check("fwd_dm_rd", dm_rd, 0);
        tick();
        wait_empty("fwd_drained");
`else
        // Matching load stalls while the store drains, then reads the new value
        st_valid = 1'b1; st_addr = 32'h4; st_data = 32'h55;
        tick();
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h4;
        mid();
        check("stall_ld_stall", ld_stall, 1);
        check("stall_dm_wr", dm_wr, 1);
        check("stall_dm_addr", dm_addr, 32'h4);
        check("stall_dm_rd", dm_rd, 0);
        tick();
        mid();
        check("stall_release", ld_stall, 0);
        check("stall_ld_data", ld_data, 32'h55);
        tick();
        wait_empty("stall_drained");
`endif

        // Reset mid-operation discards pending stores immediately
        ld_valid = 1'b1; ld_addr = 32'h0;
        for (int j = 0; j < 3; j++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * j); st_data = 32'h300 + 32'(j);
            tick();
        end
        st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        check("mrst_pre_dm_wr", dm_wr, 1);
        check("mrst_pre_count", count, 3);
        #1 reset = 1'b0;
        #1;
        check("mrst_dm_wr", dm_wr, 0);
        check("mrst_count", count, 0);
        check("mrst_empty", empty, 1);
        mid();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        load_check("mrst_no_write0", 32'h40, 32'hFFFF_FFCC);
        load_check("mrst_no_write1", 32'h44, 32'hFFFF_FFC8);

        // Random traffic checked by the model every cycle
        for (int c = 0; c < 600; c++) begin
            int r;
            r = $urandom_range(0, 99);
            st_valid = 1'b0;
            ld_valid = 1'b0;
            if (r < 40) begin
                st_valid = 1'b1;
                st_addr  = 32'($urandom_range(0, 15) * 4);
                st_data  = $urandom;
            end else if (r < 70) begin
                ld_valid = 1'b1;
                ld_addr  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            end
            tick();
        end
        wait_empty("rand_drained");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
